// File: rtl/decoder_3to8_if.sv
// Select/strobe bus between a code source and the 3-to-8 decoder.
// Latency: n/a (wires only); the decoder registers out/out_valid one cycle after en/in.
// Backpressure: none; the source may present a new code every cycle.
interface decoder_3to8_if;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;
  logic       out_valid;

  // Code source side: drives the select, observes the decoded strobe.
  modport master (
    output en,
    output in,
    input  out,
    input  out_valid
  );

  // Decoder side: samples the select, drives the registered strobe.
  modport slave (
    input  en,
    input  in,
    output out,
    output out_valid
  );
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable; build macro DECODER_3TO8_ACTIVE_LOW_EN selects active-low out (74x138 style).
// Latency: 1 cycle from en/in sampled at a rising clk edge to out/out_valid.
// Backpressure: none; accepts one code per cycle, out_valid is always active-high.
module decoder_3to8 (
  input  logic           clk,
  input  logic           rst_n,
  decoder_3to8_if.slave  bus
);

  // Pattern shown while disabled or in reset: no line asserted in either polarity.
`ifdef DECODER_3TO8_ACTIVE_LOW_EN
  localparam logic [7:0] OUT_IDLE = 8'hFF;
`else
  localparam logic [7:0] OUT_IDLE = 8'h00;
`endif

  logic [7:0] onehot;
  logic [7:0] out_d;
  logic [7:0] out_q;
  logic       out_valid_d;
  logic       out_valid_q;

  // Next-state: decode the select into one asserted line, or the idle pattern when disabled.
  always_comb begin
    onehot      = 8'd1 << bus.in;
    out_d       = OUT_IDLE;
    out_valid_d = 1'b0;
    if (bus.en) begin
`ifdef DECODER_3TO8_ACTIVE_LOW_EN
      out_d = ~onehot;
`else
      out_d = onehot;
`endif
      out_valid_d = 1'b1;
    end
  end

  // Capture the decode so consumers see a glitch-free word; reset clears it without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= OUT_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed reset/sweep/enable tests plus random traffic.
// Latency: expects out/out_valid one clk after en/in are applied.
// Backpressure: none; a new code is driven every cycle.
`timescale 1ns/1ps
module tb_decoder_3to8;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  decoder_3to8_if bus ();

  decoder_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
  localparam bit         ACT_LOW = 1'b1;
  localparam logic [7:0] INACT   = 8'hFF;
  logic [7:0] sweep_lit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] lit_code3 = 8'hF7;
  logic [7:0] lit_code5 = 8'hDF;
  logic [7:0] lit_code6 = 8'hBF;
`else
  localparam bit         ACT_LOW = 1'b0;
  localparam logic [7:0] INACT   = 8'h00;
  logic [7:0] sweep_lit [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] lit_code3 = 8'h08;
  logic [7:0] lit_code5 = 8'h20;
  logic [7:0] lit_code6 = 8'h40;
`endif

  // Reference mapping: code k asserts line k, i.e. the value 2**k, inverted for active-low.
  function automatic logic [7:0] ref_code(int k);
    logic [7:0] v;
    v = 8'(2 ** k);
    return ACT_LOW ? ~v : v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the outputs are the previous cycle's sampled inputs run through the mapping.
  logic [7:0] m_out;
  logic       m_vld;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= INACT;
      m_vld <= 1'b0;
    end else begin
      m_vld <= bus.en;
      m_out <= bus.en ? ref_code(int'(bus.in)) : INACT;
    end
  end

  // Compare DUT against the model every cycle, away from the sampling edge.
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      chk("model_out", bus.out, m_out);
      chk("model_vld", {7'd0, bus.out_valid}, {7'd0, m_vld});
      chk("onehot", 8'($countones(ACT_LOW ? ~bus.out : bus.out)), {7'd0, bus.out_valid});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low with a live enable/code: idle pattern with no clock edge required.
    bus.en = 1'b1;
    bus.in = 3'b101;
    #3;
    chk("rst_out_noclk", bus.out, INACT);
    chk("rst_vld_noclk", {7'd0, bus.out_valid}, 8'd0);
    repeat (2) step();
    chk("rst_out_held", bus.out, INACT);
    chk("rst_vld_held", {7'd0, bus.out_valid}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_out", bus.out, lit_code5);
    chk("post_rst_vld", {7'd0, bus.out_valid}, 8'd1);
    mon_on = 1'b1;

    // Sweep all codes back to back, with an asynchronous reset pulse while code 6 is pending.
    for (int k = 0; k < 8; k++) begin
      bus.en = 1'b1;
      bus.in = 3'(k);
      if (k == 6) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", bus.out, INACT);
        chk("midrst_vld", {7'd0, bus.out_valid}, 8'd0);
        rst_n = 1'b1;
      end
      step();
      chk("sweep_out", bus.out, sweep_lit[k]);
      chk("sweep_vld", {7'd0, bus.out_valid}, 8'd1);
    end
    chk("resume_code6_pin", ref_code(6), lit_code6);

    // Enable gating on a fixed code: disabled cycle shows the idle pattern, not a held value.
    bus.in = 3'b011;
    bus.en = 1'b1; step();
    chk("gate_on1_out", bus.out, lit_code3);
    chk("gate_on1_vld", {7'd0, bus.out_valid}, 8'd1);
    bus.en = 1'b0; step();
    chk("gate_off_out", bus.out, INACT);
    chk("gate_off_vld", {7'd0, bus.out_valid}, 8'd0);
    bus.en = 1'b1; step();
    chk("gate_on2_out", bus.out, lit_code3);
    chk("gate_on2_vld", {7'd0, bus.out_valid}, 8'd1);

    // Random traffic: en and code change together each cycle; compare process checks each one.
    for (int i = 0; i < 1000; i++) begin
      bus.en = 1'($urandom_range(0, 1));
      bus.in = 3'($urandom_range(0, 7));
      step();
    end

    bus.en = 1'b0;
    step();
    mon_on = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
